multicycle_chunk_adder: RTL and testbench
=========================================

// Module: multicycle_chunk_adder
//
// PURPOSE
//   Parametrised multi-cycle adder/subtractor that supersedes the fixed 4-bit ripple-carry adder.
//   WIDTH-bit operands are processed CHUNK bits per clock through one CHUNK-bit ripple-carry slice,
//   with the carry held in a register between chunks (area-for-latency trade).
//   Start/busy/done handshake, subtract mode and signed-overflow flag.
//   Drop-in arithmetic unit for datapaths that tolerate multi-cycle latency.
//
// PARAMETERS
//   WIDTH  16  operand/result width in bits; must be an integer multiple of CHUNK
//   CHUNK   4  bits added per clock (ripple slice width); 1 <= CHUNK <= WIDTH
//   (localparam N_CHUNKS = WIDTH/CHUNK; index counter width = max(1, clog2(N_CHUNKS)))
//
// PORTS
//   clk    in   1      single clock; all state updates on rising edge
//   rst_n  in   1      synchronous reset, active low
//   start  in   1      request operation; sampled only in IDLE
//   a      in   WIDTH  operand A; latched on accepted start
//   b      in   WIDTH  operand B; latched on accepted start
//   cin    in   1      carry-in; used only when sub=0; latched on accepted start
//   sub    in   1      0: S = A+B+cin; 1: S = A-B (A + ~B + 1, cin ignored); latched on accepted start
//   busy   out  1      1 while in RUN
//   done   out  1      registered one-cycle pulse: s/cout/ovf just updated
//   s      out  WIDTH  result; updated only when done rises; otherwise holds
//   cout   out  1      carry out of bit WIDTH-1; for sub, 1 = no borrow
//   ovf    out  1      signed overflow = carry into MSB XOR carry out of MSB
//
// BEHAVIOUR
//   - Reset (rst_n=0 at an edge): state=IDLE, idx=0, busy=0, done=0, s=0, cout=0, ovf=0.
//     Internal operand, partial-result and carry registers are cleared.
//     Reset during RUN aborts the operation: no done pulse, s is not updated.
//   - FSM states are IDLE and RUN.
//     IDLE and start=1: latch a; latch b (or ~b if sub); carry_r = sub ? 1 : cin; idx=0; go to RUN.
//     RUN: each cycle adds chunk idx, i.e. bits [idx*CHUNK +: CHUNK], as op_a + op_b + carry_r.
//       The sum is written into the partial register; carry_r <= the slice carry-out; idx <= idx+1.
//     RUN and idx == N_CHUNKS-1: on that edge load s <= {final chunk, partial}, load cout and ovf,
//       set done=1, go to IDLE.
//   - Latency: start accepted at edge E0; done=1 and new s are visible after edge E_N_CHUNKS.
//     For example, WIDTH=16, CHUNK=4 gives 4 cycles; CHUNK=WIDTH gives 1 cycle.
//   - done is high for exactly one cycle.
//     The done cycle is an IDLE cycle, so start there is accepted (back-to-back ops, no bubble).
//   - start while busy=1 is ignored and not queued.
//     Changes on a/b/cin/sub during RUN have no effect.
//   - Arithmetic is modulo 2^WIDTH. cout is the natural carry out.
//     ovf is computed from the MSB slice's internal carries.
//     The slice is a pure ripple chain of full adders, with no behavioural '+' across chunks.
//
// TESTING (WIDTH=16, CHUNK=4 unless stated)
//   1. a=0x0003, b=0x0001, cin=0, sub=0 -> done exactly 4 cycles after the start edge;
//      s=0x0004, cout=0, ovf=0; busy high for 4 cycles.
//   2. a=0xFFFF, b=0xFFFF, cin=1 -> s=0xFFFF, cout=1, ovf=0.
//      a=0x7FFF, b=0x0001, cin=0 -> s=0x8000, cout=0, ovf=1.
//   3. sub=1: a=0x0005, b=0x0007 -> s=0xFFFE, cout=0.
//      sub=1: a=0x8000, b=0x0001 -> s=0x7FFF, cout=1, ovf=1; cin=1 is ignored in both.
//   4. Hold start=1 with new operands during RUN -> ignored, first result correct.
//      Start in the done cycle -> second done exactly 4 cycles later; s holds between the two dones.
//   5. rst_n=0 at the 2nd RUN edge -> next cycle busy=0, done=0, s=0; no done pulse appears later.
//   6. WIDTH=CHUNK=4 and WIDTH=8/CHUNK=1: exhaustive a, b, cin, sub vs golden {cout,s};
//      check latency is 1 and 8 cycles respectively.

Source files
------------

// File: rtl/multicycle_chunk_adder.sv
//----------------------------------------------------------------------------
// multicycle_chunk_adder
//
// Multi-cycle adder/subtractor. WIDTH-bit operands pass through a single
// CHUNK-bit ripple-carry slice, one chunk per clock, least significant chunk
// first. The carry between chunks is held in a register. The unit has a
// start/busy/done handshake, a subtract mode and a signed-overflow flag.
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   rst_n  : synchronous reset, active low
//   start  : request an operation; sampled only while idle
//   a, b   : operands, latched when start is accepted
//   cin    : carry-in for add mode, latched when start is accepted
//   sub    : 0 -> s = a + b + cin, 1 -> s = a - b (cin ignored)
//   busy   : high while chunks are being processed
//   done   : one-cycle pulse; s/cout/ovf have just been updated
//   s      : result, changes only together with done
//   cout   : carry out of the MSB (in subtract mode, 1 = no borrow)
//   ovf    : signed overflow of the whole operation
//----------------------------------------------------------------------------
module multicycle_chunk_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int N_CHUNKS = WIDTH / CHUNK;
   localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e           state_q,   state_d;
   logic [IDX_W-1:0] idx_q,     idx_d;
   logic [WIDTH-1:0] op_a_q,    op_a_d;
   logic [WIDTH-1:0] op_b_q,    op_b_d;
   logic             carry_q,   carry_d;
   logic [WIDTH-1:0] partial_q, partial_d;
   logic [WIDTH-1:0] s_q,       s_d;
   logic             cout_q,    cout_d;
   logic             ovf_q,     ovf_d;
   logic             done_q,    done_d;

   logic [CHUNK-1:0] slice_a;
   logic [CHUNK-1:0] slice_b;
   logic [CHUNK-1:0] slice_sum;
   logic             slice_cout;
   logic             msb_cin;     // carry into the top bit of the slice

   // The ripple slice: a chain of full adders over the current chunk.
   // Operands stay put; the chunk is selected by shifting with idx.
   always_comb begin
      logic c;
      slice_a = CHUNK'(op_a_q >> (int'(idx_q) * CHUNK));
      slice_b = CHUNK'(op_b_q >> (int'(idx_q) * CHUNK));
      c       = carry_q;
      msb_cin = 1'b0;
      for (int i = 0; i < CHUNK; i++) begin
         if (i == CHUNK - 1) msb_cin = c;
         slice_sum[i] = slice_a[i] ^ slice_b[i] ^ c;
         c = (slice_a[i] & slice_b[i]) | (c & (slice_a[i] ^ slice_b[i]));
      end
      slice_cout = c;
   end

   // Next-state logic.
   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      carry_d   = carry_q;
      partial_d = partial_q;
      s_d       = s_q;
      cout_d    = cout_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               // Subtraction is A + ~B + 1: invert B and force the carry-in.
               op_a_d    = a;
               op_b_d    = sub ? ~b : b;
               carry_d   = sub ? 1'b1 : cin;
               idx_d     = '0;
               partial_d = '0;
               state_d   = RUN;
            end
         end
         RUN: begin
            // partial is cleared at start, so OR-ing each chunk in place is exact.
            partial_d = partial_q | (WIDTH'(slice_sum) << (int'(idx_q) * CHUNK));
            carry_d   = slice_cout;
            idx_d     = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               s_d     = partial_d;
               cout_d  = slice_cout;
               ovf_d   = msb_cin ^ slice_cout;
               done_d  = 1'b1;
               idx_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the reset clears every register, including the datapath,
         // so an aborted operation leaves no stale result behind.
         state_q   <= IDLE;
         idx_q     <= '0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         carry_q   <= 1'b0;
         partial_q <= '0;
         s_q       <= '0;
         cout_q    <= 1'b0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         carry_q   <= carry_d;
         partial_q <= partial_d;
         s_q       <= s_d;
         cout_q    <= cout_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign s    = s_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_multicycle_chunk_adder.sv
//----------------------------------------------------------------------------
// tb_multicycle_chunk_adder
//
// Drives three instances of multicycle_chunk_adder (16/4, 4/4 and 8/1) and
// compares every result against an arithmetic reference model.
//----------------------------------------------------------------------------
module tb_multicycle_chunk_adder;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   // Per-instance stimulus: index 0 = 16/4, 1 = 4/4, 2 = 8/1.
   logic        start_v [3];
   logic [15:0] a_v     [3];
   logic [15:0] b_v     [3];
   logic        cin_v   [3];
   logic        sub_v   [3];

   logic        busy0, busy1, busy2;
   logic        done0, done1, done2;
   logic        cout0, cout1, cout2;
   logic        ovf0,  ovf1,  ovf2;
   logic [15:0] s0;
   logic [3:0]  s1;
   logic [7:0]  s2;

   logic        busy_v [3];
   logic        done_v [3];
   logic        cout_v [3];
   logic        ovf_v  [3];
   logic [15:0] s_v    [3];

   int n_assert = 0;
   int n_fail   = 0;

   multicycle_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]),
      .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]), .sub(sub_v[0]),
      .busy(busy0), .done(done0), .s(s0), .cout(cout0), .ovf(ovf0)
   );

   multicycle_chunk_adder #(.WIDTH(4), .CHUNK(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]),
      .a(a_v[1][3:0]), .b(b_v[1][3:0]), .cin(cin_v[1]), .sub(sub_v[1]),
      .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1)
   );

   multicycle_chunk_adder #(.WIDTH(8), .CHUNK(1)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]),
      .a(a_v[2][7:0]), .b(b_v[2][7:0]), .cin(cin_v[2]), .sub(sub_v[2]),
      .busy(busy2), .done(done2), .s(s2), .cout(cout2), .ovf(ovf2)
   );

   always_comb begin
      busy_v[0] = busy0;  busy_v[1] = busy1;  busy_v[2] = busy2;
      done_v[0] = done0;  done_v[1] = done1;  done_v[2] = done2;
      cout_v[0] = cout0;  cout_v[1] = cout1;  cout_v[2] = cout2;
      ovf_v[0]  = ovf0;   ovf_v[1]  = ovf1;   ovf_v[2]  = ovf2;
      s_v[0]    = s0;
      s_v[1]    = {12'b0, s1};
      s_v[2]    = {8'b0, s2};
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on unsigned and signed views.
   function automatic void model(input int w, input longint av, input longint bv,
                                 input bit cv, input bit sv,
                                 output longint es, output bit eco, output bit eov);
      longint m, half, sa, sb, u, t;
      m    = 64'sd1 << w;
      half = m / 2;
      sa   = (av >= half) ? av - m : av;
      sb   = (bv >= half) ? bv - m : bv;
      if (sv) begin
         u   = av - bv;
         eco = (av >= bv);
         t   = sa - sb;
      end else begin
         u   = av + bv + longint'(cv);
         eco = (u >= m);
         t   = sa + sb + longint'(cv);
      end
      es  = u & (m - 1);
      eov = (t >= half) || (t < -half);
   endfunction

   // One clock, then sample a little after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until done is seen or the budget runs out; counts busy samples.
   task automatic wait_done(input int k, input int budget, output int n, output int bc);
      n  = 0;
      bc = 0;
      do begin
         tick();
         n++;
         if (done_v[k] !== 1'b1 && busy_v[k] === 1'b1) bc++;
      end while (done_v[k] !== 1'b1 && n < budget);
   endtask

   // Full transaction; operands are scrambled right after acceptance.
   task automatic run_op(input int k, input int w, input int lat,
                         input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic sv, input string tag);
      longint es;
      bit     eco, eov;
      int     n, bc;
      model(w, longint'(av), longint'(bv), cv, sv, es, eco, eov);
      start_v[k] = 1'b1;
      a_v[k]     = av;
      b_v[k]     = bv;
      cin_v[k]   = cv;
      sub_v[k]   = sv;
      tick();
      start_v[k] = 1'b0;
      a_v[k]     = 16'($urandom);
      b_v[k]     = 16'($urandom);
      cin_v[k]   = 1'($urandom);
      sub_v[k]   = 1'($urandom);
      bc = (busy_v[k] === 1'b1) ? 1 : 0;
      begin
         int bc2;
         wait_done(k, lat + 8, n, bc2);
         bc += bc2;
      end
      check({tag, "_done"},    done_v[k], 1);
      check({tag, "_latency"}, n, lat);
      check({tag, "_busy"},    bc, lat);
      check({tag, "_s"},       s_v[k], es);
      check({tag, "_cout"},    cout_v[k], eco);
      check({tag, "_ovf"},     ovf_v[k], eov);
   endtask

   initial begin
      longint e1_s, e2_s;
      bit     e1_c, e1_o, e2_c, e2_o;
      int     n, bc;
      bit     seen;

      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         start_v[k] = 1'b0;
         a_v[k]     = '0;
         b_v[k]     = '0;
         cin_v[k]   = 1'b0;
         sub_v[k]   = 1'b0;
      end
      repeat (3) tick();
      for (int k = 0; k < 3; k++) begin
         check("reset_busy", busy_v[k], 0);
         check("reset_done", done_v[k], 0);
         check("reset_s",    s_v[k],    0);
         check("reset_cout", cout_v[k], 0);
         check("reset_ovf",  ovf_v[k],  0);
      end
      rst_n = 1'b1;
      tick();

      // Directed cases on the 16/4 unit.
      run_op(0, 16, 4, 16'h0003, 16'h0001, 1'b0, 1'b0, "add_small");
      run_op(0, 16, 4, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "add_allones");
      run_op(0, 16, 4, 16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_ovf");
      run_op(0, 16, 4, 16'h0005, 16'h0007, 1'b1, 1'b1, "sub_borrow");
      run_op(0, 16, 4, 16'h8000, 16'h0001, 1'b1, 1'b1, "sub_ovf");
      run_op(0, 16, 4, 16'h0000, 16'h0000, 1'b0, 1'b1, "sub_zero");

      // Random traffic on the 16/4 unit.
      for (int i = 0; i < 150; i++)
         run_op(0, 16, 4, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rnd16");

      // start held through RUN with new operands, then accepted in the done cycle.
      model(16, 64'h1234, 64'h0F0F, 1'b1, 1'b0, e1_s, e1_c, e1_o);
      model(16, 64'h8001, 64'h0002, 1'b0, 1'b1, e2_s, e2_c, e2_o);
      start_v[0] = 1'b1;
      a_v[0] = 16'h1234;  b_v[0] = 16'h0F0F;  cin_v[0] = 1'b1;  sub_v[0] = 1'b0;
      tick();
      a_v[0] = 16'h8001;  b_v[0] = 16'h0002;  cin_v[0] = 1'b0;  sub_v[0] = 1'b1;
      wait_done(0, 12, n, bc);
      check("held_first_latency", n, 4);
      check("held_first_s",       s_v[0], e1_s);
      check("held_first_cout",    cout_v[0], e1_c);
      tick();
      start_v[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("b2b_s_hold",  s_v[0], e1_s);
         check("b2b_no_done", done_v[0], 0);
         tick();
      end
      check("b2b_done", done_v[0], 1);
      check("b2b_s",    s_v[0], e2_s);
      check("b2b_cout", cout_v[0], e2_c);
      check("b2b_ovf",  ovf_v[0], e2_o);

      // Reset at the second RUN edge aborts the operation.
      start_v[0] = 1'b1;
      a_v[0] = 16'h1111;  b_v[0] = 16'h2222;  cin_v[0] = 1'b0;  sub_v[0] = 1'b0;
      tick();
      start_v[0] = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort_busy", busy_v[0], 0);
      check("abort_done", done_v[0], 0);
      check("abort_s",    s_v[0],    0);
      check("abort_cout", cout_v[0], 0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done_v[0] !== 1'b0) seen = 1'b1;
      end
      check("abort_no_late_done", seen, 0);

      // 4/4 unit: exhaustive.
      for (int ai = 0; ai < 16; ai++)
         for (int bi = 0; bi < 16; bi++)
            for (int ci = 0; ci < 2; ci++)
               for (int si = 0; si < 2; si++)
                  run_op(1, 4, 1, 16'(ai), 16'(bi), 1'(ci), 1'(si), "w4");

      // 8/1 unit: corners plus random.
      run_op(2, 8, 8, 16'h00FF, 16'h00FF, 1'b1, 1'b0, "w8_allones");
      run_op(2, 8, 8, 16'h007F, 16'h0001, 1'b0, 1'b0, "w8_addovf");
      run_op(2, 8, 8, 16'h0080, 16'h0001, 1'b1, 1'b1, "w8_subovf");
      run_op(2, 8, 8, 16'h0000, 16'h0000, 1'b0, 1'b1, "w8_subzero");
      for (int i = 0; i < 300; i++)
         run_op(2, 8, 8, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
                1'($urandom), 1'($urandom), "w8_rnd");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
